pipeline_hazard_ctrl: RTL

//  Sequencer for the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch flush, dcache-wait freeze.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MEM_TIMEOUT       = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RegisterRT_i,
    input  logic [4:0]  IFID_RegisterRS_i,
    input  logic [4:0]  IFID_RegisterRT_i,
    input  logic        Branch_taken_i,
    input  logic        dcache_req_i,
    input  logic        dcache_ack_i,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        IFIDFlush_o,
    output logic        IDEXWrite_o,
    output logic        IDEXBubble_o,
    output logic        EXMEMWrite_o,
    output logic        MEMWBBubble_o,
    output logic        mem_err_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] memwait_cnt_o
);

    typedef enum logic [1:0] {ST_RUN, ST_LU_STALL, ST_MEM_WAIT} state_e;

    localparam logic [3:0]  LSC_LAST = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [15:0] TMO_MAX  = 16'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] tmo_inc;
    logic        err_q, err_d;
    logic        lu, miss;
    logic        freeze, lu_stall, flush;

    always_comb begin
        lu = IDEX_MemRead_i && (IDEX_RegisterRT_i != 5'd0) &&
             ((IDEX_RegisterRT_i == IFID_RegisterRS_i) ||
              (IDEX_RegisterRT_i == IFID_RegisterRT_i));
        miss     = dcache_req_i && !dcache_ack_i;
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        freeze   = 1'b0;
        lu_stall = 1'b0;
        flush    = 1'b0;
        tmo_inc  = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;

        if (state_q == ST_MEM_WAIT && !dcache_ack_i) begin
            freeze = 1'b1;
            tmo_d  = tmo_inc;
            if (tmo_inc >= TMO_MAX) begin
                err_d   = 1'b1;
                state_d = ST_RUN;
            end
        end else if (state_q == ST_LU_STALL) begin
            if (miss) begin
                freeze  = 1'b1;
                state_d = ST_MEM_WAIT;
                tmo_d   = 16'd1;
                cnt_d   = '0;
            end else begin
                lu_stall = 1'b1;
                if (cnt_q == LSC_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end else begin
            // RUN, or the MEM_WAIT cycle where the ack arrives (evaluated as RUN)
            state_d = ST_RUN;
            if (miss) begin
                freeze  = 1'b1;
                state_d = ST_MEM_WAIT;
                tmo_d   = 16'd1;
            end else if (lu) begin
                lu_stall = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    state_d = ST_LU_STALL;
                    cnt_d   = 4'd1;
                end
            end else if (Branch_taken_i) begin
                flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        if (rst_i) begin
            PCWrite_o     = 1'b0;
            IFIDWrite_o   = 1'b0;
            IFIDFlush_o   = 1'b1;
            IDEXWrite_o   = 1'b0;
            IDEXBubble_o  = 1'b1;
            EXMEMWrite_o  = 1'b0;
            MEMWBBubble_o = 1'b1;
        end else begin
            PCWrite_o     = !(freeze || lu_stall);
            IFIDWrite_o   = !(freeze || lu_stall);
            IFIDFlush_o   = flush;
            IDEXWrite_o   = !freeze;
            IDEXBubble_o  = lu_stall;
            EXMEMWrite_o  = !freeze;
            MEMWBBubble_o = freeze;
        end
    end

    assign mem_err_o = err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            memwait_cnt_q <= '0;
        end else begin
            if (lu_stall) stall_cnt_q   <= stall_cnt_q + 32'd1;
            if (flush)    flush_cnt_q   <= flush_cnt_q + 32'd1;
            if (freeze)   memwait_cnt_q <= memwait_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign memwait_cnt_o = memwait_cnt_q;
`else
    assign stall_cnt_o   = '0;
    assign flush_cnt_o   = '0;
    assign memwait_cnt_o = '0;
`endif

endmodule
